instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/constants_pkg.sv | 16 +
 rtl/instruction_fetch.sv | 73 +++++++
 2 files changed

// File: rtl/constants_pkg.sv
// Shared widths and the fetch FSM state encoding for the instruction fetch path.
package constants_pkg;

  localparam int MEMORY_ADDRESS_BITS      = 8;
  localparam int MEMORY_DATA_BITS         = 8;
  localparam int INSTRUCTION_POINTER_BITS = 8;
  localparam int INSTRUCTION_BITS         = 16;

  typedef enum logic [1:0] {
    FETCH_HI,
    FETCH_LO,
    CAPTURE_LO,
    HOLD
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Fetches 16-bit big-endian instructions as two byte reads from a 1-cycle-latency ram
// and presents them to the execution stage with a valid/ready handshake and redirect.
module instruction_fetch
  import constants_pkg::*;
#(
  parameter logic [INSTRUCTION_POINTER_BITS-1:0] RESET_VECTOR = 8'h00
) (
  input  logic                                clk,
  input  logic                                reset,
  output logic [MEMORY_ADDRESS_BITS-1:0]      mem_address,
  output logic                                mem_read_en,
  input  logic [MEMORY_DATA_BITS-1:0]         mem_data_in,
  output logic [INSTRUCTION_BITS-1:0]         instr,
  output logic [INSTRUCTION_POINTER_BITS-1:0] instr_pc,
  output logic                                instr_valid,
  input  logic                                instr_ready,
  input  logic                                redirect_en,
  input  logic [INSTRUCTION_POINTER_BITS-1:0] redirect_target
);

  localparam logic [INSTRUCTION_POINTER_BITS-1:0] IP_ONE = INSTRUCTION_POINTER_BITS'(1);
  localparam logic [INSTRUCTION_POINTER_BITS-1:0] IP_TWO = INSTRUCTION_POINTER_BITS'(2);

  fetch_state_t                          state_reg;
  logic [INSTRUCTION_POINTER_BITS-1:0]   ip_reg;
  logic [MEMORY_DATA_BITS-1:0]           instr_buf_hi_reg;

  // Address always tracks ip; the strobe is held off while reset is asserted.
  assign mem_address = MEMORY_ADDRESS_BITS'(ip_reg);
  assign mem_read_en = !reset && (state_reg == FETCH_HI || state_reg == FETCH_LO);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= FETCH_HI;
      ip_reg           <= RESET_VECTOR;
      instr            <= '0;
      instr_pc         <= '0;
      instr_buf_hi_reg <= '0;
      instr_valid      <= 1'b0;
    end else if (redirect_en) begin
      // Redirect wins over a simultaneous handshake; any in-flight byte is dropped.
      state_reg   <= FETCH_HI;
      ip_reg      <= redirect_target;
      instr_valid <= 1'b0;
    end else begin
      case (state_reg)
        FETCH_HI: begin
          ip_reg    <= ip_reg + IP_ONE;
          state_reg <= FETCH_LO;
        end
        FETCH_LO: begin
          instr_buf_hi_reg <= mem_data_in;
          ip_reg           <= ip_reg + IP_ONE;
          state_reg        <= CAPTURE_LO;
        end
        CAPTURE_LO: begin
          instr       <= {instr_buf_hi_reg, mem_data_in};
          instr_pc    <= ip_reg - IP_TWO;
          instr_valid <= 1'b1;
          state_reg   <= HOLD;
        end
        HOLD: begin
          if (instr_valid && instr_ready) begin
            instr_valid <= 1'b0;
            state_reg   <= FETCH_HI;
          end
        end
        default: state_reg <= FETCH_HI;
      endcase
    end
  end

endmodule
